irq_sched_riscv: RTL and testbench

Rotating-priority interrupt scheduler for the RISC-V core. It arbitrates up to 32 level-sensitive interrupt lines under the `mie` mask and global enable, then sequences each accepted interrupt through a grant / trap-accept / mret / finish handshake with the core. It supplies `mcause` to the CSR file and pulses a one-hot finish line back to the interrupting source. It sits between the peripheral interrupt lines and the core's trap/CSR logic.

---
 rtl/irq_sched_riscv_pkg.sv | 9 +
 rtl/irq_sched_riscv_rr_arbiter.sv | 23 ++
 rtl/irq_sched_riscv.sv | 75 +++++++
 tb/tb_irq_sched_riscv.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_riscv_pkg.sv
// irq_pkg: shared types, limits and mcause packing for the interrupt scheduler
package irq_pkg;
  typedef enum logic [1:0] {IDLE, SIGNAL, ACTIVE, FIN} irq_state_t;
  localparam int IRQ_MAX = 32;
  localparam int CAUSE_W = 5;
  function automatic logic [31:0] pack_mcause(input logic [CAUSE_W-1:0] id);
    return {27'h0, id};
  endfunction
endpackage

// File: rtl/irq_sched_riscv_rr_arbiter.sv
// rr_arbiter: combinational rotating find-first starting at ptr, wrapping at N-1
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] id_o
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  // rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back
  always_comb begin
    rot = N'({elig_i, elig_i} >> ptr_i);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    sum = {1'b0, ptr_i} + {1'b0, off};
    found_o = |elig_i;
    id_o = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  end
endmodule

// File: rtl/irq_sched_riscv.sv
// irq_sched_riscv: rotating-priority interrupt scheduler with grant/ack/mret/finish handshake
module irq_sched_riscv
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [IRQ_MAX-1:0] mie_i,
  input  logic               mstatus_mie_i,
  input  logic [N_IRQ-1:0]   int_req_i,
  input  logic               int_ack_i,
  input  logic               int_rst_i,
  output logic               int_o,
  output logic [31:0]        mcause_o,
  output logic [N_IRQ-1:0]   int_fin_o,
  output logic               busy_o
);
  localparam int PW = $clog2(N_IRQ);
  irq_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, id_q, id_d, arb_id;
  logic [31:0]   mcause_q, mcause_d;
  logic [N_IRQ-1:0] elig;
  logic          arb_found;
  logic          unused_mie;
  assign unused_mie = ^mie_i;
  assign elig = mstatus_mie_i ? (int_req_i & mie_i[N_IRQ-1:0]) : '0;
  rr_arbiter #(.N(N_IRQ), .W(PW)) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .found_o(arb_found),
    .id_o   (arb_id)
  );
  // state, pointer, latched id and mcause registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      mcause_q <= mcause_d;
    end
  end
  // next state plus grant latch in IDLE and pointer advance in FIN
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    mcause_d = mcause_q;
    case (state_q)
      IDLE: if (arb_found) begin
        state_d  = SIGNAL;
        id_d     = arb_id;
        mcause_d = pack_mcause(CAUSE_W'(arb_id));
      end
      SIGNAL: state_d = int_ack_i ? ACTIVE : SIGNAL;
      ACTIVE: state_d = int_rst_i ? FIN : ACTIVE;
      default: begin
        state_d = IDLE;
        ptr_d   = (id_q == PW'(N_IRQ - 1)) ? '0 : id_q + 1'b1;
      end
    endcase
  end
  // outputs decoded from registered state only
  always_comb begin
    int_o     = state_q == SIGNAL;
    busy_o    = state_q != IDLE;
    int_fin_o = (state_q == FIN) ? (N_IRQ'(1) << id_q) : '0;
    mcause_o  = mcause_q;
  end
endmodule

// File: tb/tb_irq_sched_riscv.sv
// tb_irq_sched_riscv: directed self-checking bench for the interrupt scheduler
module tb_irq_sched_riscv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mie;
  logic        gie;
  logic [15:0] req;
  logic        ack, mret;
  logic        int_o, busy;
  logic [31:0] mcause;
  logic [15:0] fin;
  int n_pass = 0;
  int n_tot  = 0;

  irq_sched_riscv #(.N_IRQ(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .mie_i        (mie),
    .mstatus_mie_i(gie),
    .int_req_i    (req),
    .int_ack_i    (ack),
    .int_rst_i    (mret),
    .int_o        (int_o),
    .mcause_o     (mcause),
    .int_fin_o    (fin),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic outs_idle(input string tag);
    chk({tag, "_int"}, {31'h0, int_o}, 32'h0);
    chk({tag, "_fin"}, {16'h0, fin}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // full minimum-length interrupt: grant, ack first chance, mret first chance
  task automatic do_irq(input int exp_id);
    step();
    chk($sformatf("grant%0d_int", exp_id), {31'h0, int_o}, 32'h1);
    chk($sformatf("grant%0d_cause", exp_id), mcause, exp_id);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk($sformatf("ack%0d_int", exp_id), {31'h0, int_o}, 32'h0);
    chk($sformatf("ack%0d_busy", exp_id), {31'h0, busy}, 32'h1);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk($sformatf("fin%0d", exp_id), {16'h0, fin}, 32'h1 << exp_id);
    step();
    chk($sformatf("idle%0d_fin", exp_id), {16'h0, fin}, 32'h0);
    chk($sformatf("idle%0d_busy", exp_id), {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; mret = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mie = $urandom; gie = 1'($urandom); req = 16'($urandom);
      ack = 1'($urandom); mret = 1'($urandom);
      step();
      outs_idle("rst");
      chk("rst_cause", mcause, 32'h0);
    end
    mie = 32'hffff_ffff; gie = 1'b1; req = 16'h0; ack = 1'b0; mret = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      outs_idle("norq");
    end

    req = 16'h8009;
    do_irq(0);
    do_irq(3);
    do_irq(15);
    do_irq(0);
    req = 16'h0;
    step();
    outs_idle("rr_done");

    // ptr now 1: single line 2 with ignored handshakes
    mret = 1'b1;
    step();
    outs_idle("mret_idle");
    mret = 1'b0;
    mie = 32'h4; req = 16'h4;
    step();
    chk("one_int", {31'h0, int_o}, 32'h1);
    chk("one_cause", mcause, 32'd2);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("mret_sig_int", {31'h0, int_o}, 32'h1);
    chk("mret_sig_fin", {16'h0, fin}, 32'h0);
    ack = 1'b1;
    step();
    chk("one_ack_int", {31'h0, int_o}, 32'h0);
    step();
    ack = 1'b0;
    chk("ack_act_int", {31'h0, int_o}, 32'h0);
    chk("ack_act_fin", {16'h0, fin}, 32'h0);
    chk("ack_act_busy", {31'h0, busy}, 32'h1);
    mret = 1'b1; req = 16'h0;
    step();
    mret = 1'b0;
    chk("one_fin", {16'h0, fin}, 32'h4);
    step();
    chk("one_fin_off", {16'h0, fin}, 32'h0);
    chk("one_idle", {31'h0, busy}, 32'h0);
    chk("one_cause_hold", mcause, 32'd2);

    // masking: global disable, then line mask clear
    gie = 1'b0; mie = 32'hffff; req = 16'h10;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("gie_off", {31'h0, int_o}, 32'h0);
    end
    gie = 1'b1; mie = 32'hffef;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mie_off", {31'h0, int_o}, 32'h0);
    end
    mie = 32'hffff;
    step();
    chk("en_int", {31'h0, int_o}, 32'h1);
    chk("en_cause", mcause, 32'd4);
    mie = 32'h0; req = 16'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("committed", {31'h0, int_o}, 32'h1);
    end
    ack = 1'b1; mret = 1'b1;
    step();
    ack = 1'b0; mret = 1'b0;
    chk("both_int", {31'h0, int_o}, 32'h0);
    chk("both_fin", {16'h0, fin}, 32'h0);
    chk("both_busy", {31'h0, busy}, 32'h1);
    step();
    chk("both_fin2", {16'h0, fin}, 32'h0);
    chk("both_busy2", {31'h0, busy}, 32'h1);
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("mask_fin", {16'h0, fin}, 32'h10);
    step();
    outs_idle("mask_idle");

    // reset in ACTIVE with id 5 (ptr is 5 here)
    mie = 32'hffff; req = 16'h20;
    step();
    chk("id5_cause", mcause, 32'd5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("id5_act", {31'h0, busy}, 32'h1);
    req = 16'h21;
    rst_n = 1'b0;
    #1;
    outs_idle("async_rst");
    chk("async_cause", mcause, 32'h0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    outs_idle("rst_hold");
    rst_n = 1'b1;
    step();
    chk("post_rst_int", {31'h0, int_o}, 32'h1);
    chk("post_rst_cause", mcause, 32'd0);
    chk("post_rst_fin", {16'h0, fin}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
